// File: rtl/player_motion_pkg.sv
// player_motion_pkg: shared state enum and fixed-point helpers for player_motion
package player_motion_pkg;
  typedef enum logic {GROUNDED = 1'b0, AIR = 1'b1} state_t;
  localparam int FP_GUARD = 2;
  function automatic int fp_w(input int pos_w, input int frac_bits);
    return pos_w + frac_bits + FP_GUARD;
  endfunction
  function automatic int to_fp(input int pix, input int frac_bits);
    return pix << frac_bits;
  endfunction
endpackage

// File: rtl/key_edge_latch.sv
// key_edge_latch: rising-edge detect of key, latched into pending while arm is high, cleared by clear; ports clk, resetN, key, arm, clear -> rise, pending
module key_edge_latch (
  input  logic clk,
  input  logic resetN,
  input  logic key,
  input  logic arm,
  input  logic clear,
  output logic rise,
  output logic pending
);
  logic prev;
  assign rise = key & ~prev;
  always_ff @(posedge clk) begin
    if (!resetN) begin
      prev    <= 1'b0;
      pending <= 1'b0;
    end else begin
      prev    <= key;
      pending <= !clear && (pending || (rise && arm));
    end
  end
endmodule

// File: rtl/player_motion.sv
// player_motion: per-frame sprite position (jump FSM + walk); in keys/freeze/start_Of_frame, out topLeftX/Y, airborne, jump_start, landed
module player_motion
  import player_motion_pkg::*;
#(
  parameter int POS_W            = 11,
  parameter int FRAC_BITS        = 6,
  parameter int INITIAL_X        = 20,
  parameter int X_MIN            = 0,
  parameter int X_MAX            = 600,
  parameter int X_SPEED          = 2,
  parameter int Y_GROUND         = 400,
  parameter int Y_MIN            = 0,
  parameter int SMALL_JUMP_SPEED = 320,
  parameter int HIGH_JUMP_SPEED  = 480,
  parameter int GRAVITY          = 32,
  parameter int MAX_FALL_SPEED   = 640
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start_Of_frame,
  input  logic             small_jump,
  input  logic             high_jump,
  input  logic             move_left,
  input  logic             move_right,
  input  logic             freeze,
  output logic [POS_W-1:0] topLeftX,
  output logic [POS_W-1:0] topLeftY,
  output logic             airborne,
  output logic             jump_start,
  output logic             landed
);
  localparam int FW = fp_w(POS_W, FRAC_BITS);
  typedef logic signed [FW-1:0] fp_t;
  localparam fp_t GROUND_FP = fp_t'(to_fp(Y_GROUND, FRAC_BITS));
  localparam fp_t YMIN_FP   = fp_t'(to_fp(Y_MIN, FRAC_BITS));
  localparam fp_t SMALL_FP  = fp_t'(SMALL_JUMP_SPEED);
  localparam fp_t HIGH_FP   = fp_t'(HIGH_JUMP_SPEED);
  localparam fp_t GRAV_FP   = fp_t'(GRAVITY);
  localparam fp_t MAXF_FP   = fp_t'(MAX_FALL_SPEED);
  localparam logic [POS_W-1:0] XINIT_P = POS_W'(INITIAL_X);
  localparam logic [POS_W-1:0] XMIN_P  = POS_W'(X_MIN);
  localparam logic [POS_W-1:0] XMAX_P  = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] XSP_P   = POS_W'(X_SPEED);
  state_t state, state_n;
  fp_t y_fp, y_n, vy, vy_n, y_sum, vy_g;
  logic [POS_W-1:0] x, x_n;
  logic grounded, step, launch, land, ceil;
  logic rise_s, rise_h, pend_s, pend_h;
  assign grounded = state == GROUNDED;
  assign step     = start_Of_frame && !freeze;
  key_edge_latch u_small (
    .clk(clk), .resetN(resetN), .key(small_jump), .arm(grounded),
    .clear(launch), .rise(rise_s), .pending(pend_s)
  );
  key_edge_latch u_high (
    .clk(clk), .resetN(resetN), .key(high_jump), .arm(grounded),
    .clear(launch), .rise(rise_h), .pending(pend_h)
  );
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state      <= GROUNDED;
      y_fp       <= GROUND_FP;
      vy         <= '0;
      x          <= XINIT_P;
      jump_start <= 1'b0;
      landed     <= 1'b0;
    end else begin
      state      <= state_n;
      y_fp       <= y_n;
      vy         <= vy_n;
      x          <= x_n;
      jump_start <= launch;
      landed     <= land;
    end
  end
  // an edge arriving in the same cycle as the frame pulse launches directly, bypassing the pending flag
  always_comb begin
    y_sum   = y_fp + vy;
    vy_g    = vy + GRAV_FP;
    launch  = grounded && step && (pend_s || pend_h || rise_s || rise_h);
    land    = !grounded && step && (y_sum >= GROUND_FP);
    ceil    = !grounded && step && !land && (y_sum < YMIN_FP);
    state_n = launch ? AIR : land ? GROUNDED : state;
    y_n     = (grounded || !step) ? y_fp : land ? GROUND_FP : ceil ? YMIN_FP : y_sum;
    vy_n    = launch ? ((pend_h || rise_h) ? -HIGH_FP : -SMALL_FP) :
              (grounded || !step) ? vy :
              (land || ceil) ? '0 :
              (vy_g > MAXF_FP) ? MAXF_FP : vy_g;
    // clamp tests run in int so x - X_SPEED can never wrap below zero
    x_n     = (!step || (move_left == move_right)) ? x :
              move_left ? ((int'(x) < X_MIN + X_SPEED) ? XMIN_P : x - XSP_P) :
              ((int'(x) + X_SPEED > X_MAX) ? XMAX_P : x + XSP_P);
  end
  always_comb begin
    topLeftX = x;
    topLeftY = POS_W'(y_fp >>> FRAC_BITS);
    airborne = state == AIR;
  end
endmodule

// File: tb/tb_player_motion.sv
// tb_player_motion: scoreboard bench for player_motion against a behavioural reference model
module tb_player_motion;
  logic clk, resetN, sof, sj, hj, ml, mr, frz;
  logic [10:0] x, y, x2, y2;
  logic air, js, ld, air2, js2, ld2;
  int n_chk = 0;
  int n_err = 0;
  typedef struct {int x; int x2; int y; int air; int js; int ld;} exp_t;
  exp_t q[$];
  int m_st, m_y, m_vy, m_x, m_x2, m_ps, m_ph, m_psj, m_phj, m_js, m_ld;

  player_motion dut (
    .clk(clk), .resetN(resetN), .start_Of_frame(sof), .small_jump(sj), .high_jump(hj),
    .move_left(ml), .move_right(mr), .freeze(frz), .topLeftX(x), .topLeftY(y),
    .airborne(air), .jump_start(js), .landed(ld)
  );
  player_motion #(.INITIAL_X(1)) dut_odd (
    .clk(clk), .resetN(resetN), .start_Of_frame(sof), .small_jump(sj), .high_jump(hj),
    .move_left(ml), .move_right(mr), .freeze(frz), .topLeftX(x2), .topLeftY(y2),
    .airborne(air2), .jump_start(js2), .landed(ld2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int xmove(input int v);
    if (ml && !mr) return (v - 2 < 0) ? 0 : v - 2;
    if (mr && !ml) return (v + 2 > 600) ? 600 : v + 2;
    return v;
  endfunction

  task automatic model_step();
    int es, eh, yn, step;
    if (!resetN) begin
      m_st = 0; m_y = 400 * 64; m_vy = 0; m_x = 20; m_x2 = 1;
      m_ps = 0; m_ph = 0; m_psj = 0; m_phj = 0; m_js = 0; m_ld = 0;
      return;
    end
    es = (sj && !m_psj) ? 1 : 0;
    eh = (hj && !m_phj) ? 1 : 0;
    m_psj = sj; m_phj = hj;
    step = (sof && !frz) ? 1 : 0;
    m_js = 0; m_ld = 0;
    if (m_st == 0) begin
      if (step && (m_ps || m_ph || es || eh)) begin
        m_vy = (m_ph || eh) ? -480 : -320;
        m_st = 1; m_js = 1; m_ps = 0; m_ph = 0;
      end else begin
        m_ps = m_ps | es;
        m_ph = m_ph | eh;
      end
    end else if (step) begin
      yn = m_y + m_vy;
      if (yn >= 400 * 64) begin
        m_y = 400 * 64; m_vy = 0; m_st = 0; m_ld = 1;
      end else if (yn < 0) begin
        m_y = 0; m_vy = 0;
      end else begin
        m_y = yn;
        m_vy = (m_vy + 32 > 640) ? 640 : m_vy + 32;
      end
    end
    if (step) begin
      m_x = xmove(m_x);
      m_x2 = xmove(m_x2);
    end
  endtask

  task automatic cyc();
    exp_t e;
    model_step();
    q.push_back('{x: m_x, x2: m_x2, y: m_y >>> 6, air: m_st, js: m_js, ld: m_ld});
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("x", x, e.x);
    check("x_odd", x2, e.x2);
    check("y", y, e.y);
    check("airborne", air, e.air);
    check("jump_start", js, e.js);
    check("landed", ld, e.ld);
  endtask

  task automatic frame();
    sof = 1'b1;
    cyc();
    sof = 1'b0;
    cyc();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  initial begin
    resetN = 1'b0; sof = 0; sj = 0; hj = 0; ml = 0; mr = 0; frz = 0;
    cyc();
    cyc();
    resetN = 1'b1;
    frames(5);
    check("idle_x", x, 20);
    check("idle_y", y, 400);
    check("idle_air", air, 0);
    ml = 1;
    frame();
    check("left_from1", x2, 0);
    frames(12);
    check("left_floor", x, 0);
    check("left_floor_odd", x2, 0);
    ml = 0; mr = 1;
    frames(305);
    check("right_ceil", x, 600);
    ml = 1;
    frames(3);
    check("both_hold", x, 600);
    ml = 0; mr = 0;
    sj = 1;
    sof = 1'b1;
    cyc();
    check("small_launch", js, 1);
    sof = 1'b0;
    cyc();
    sj = 0;
    frames(10);
    check("small_y10", y, 372);
    frames(10);
    check("small_air20", air, 1);
    sof = 1'b1;
    cyc();
    check("small_land21", ld, 1);
    check("small_land_y", y, 400);
    sof = 1'b0;
    cyc();
    hj = 1;
    frame();
    frames(4);
    sj = 1;
    frames(11);
    check("high_y15", y, 340);
    frames(15);
    check("high_air30", air, 1);
    sof = 1'b1;
    cyc();
    check("high_land31", ld, 1);
    sof = 1'b0;
    cyc();
    frames(3);
    check("no_rejump", air, 0);
    sj = 0; hj = 0;
    cyc();
    sj = 1; hj = 1;
    frame();
    frames(15);
    check("both_high_y15", y, 340);
    frames(16);
    check("both_landed", air, 0);
    sj = 0; hj = 0;
    frz = 1;
    cyc();
    sj = 1;
    frames(2);
    check("frz_ground", air, 0);
    frz = 0;
    frame();
    check("frz_pending", air, 1);
    sj = 0;
    frames(5);
    check("frz_y5", y, 380);
    frz = 1;
    frames(4);
    check("frz_hold_y", y, 380);
    frz = 0;
    frames(5);
    check("frz_resume_y10", y, 372);
    frames(11);
    check("frz_landed", air, 0);
    sj = 1;
    frame();
    sj = 0;
    frames(7);
    resetN = 0;
    sof = 1'b1;
    cyc();
    check("rst_y", y, 400);
    check("rst_air", air, 0);
    check("rst_landed", ld, 0);
    resetN = 1;
    sof = 1'b0;
    cyc();
    frames(3);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
